// File: rtl/dm_resp.sv
// dm_resp: single-port 4 KB data-memory responder with a one-cycle ack pulse after a fixed wait.
// Define DM_RESP_WAIT_EN to honour WAIT_CYCLES; undefined, every access answers one cycle after acceptance.
module dm_resp #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err,
  output logic [1:0]  state_dbg
);

  // Handshake: req is a level, sampled only in IDLE (accept edge); busy covers the
  // cycle after acceptance through the ack cycle; ack is a one-cycle pulse with rdata/err valid.
`ifdef DM_RESP_WAIT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESP = 2'd2} state_t;
`endif

  state_t state;
  state_t state_nxt;

  logic        we_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [0:1023];

  logic        accept;
  logic        enter_resp;
  logic        acc_we;
  logic [11:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_aligned;
  logic [19:0] unused_addr;

  assign unused_addr = addr[31:12];
  assign accept      = (state == S_IDLE) && req;
  assign enter_resp  = (state != S_RESP) && (state_nxt == S_RESP);

  // A zero-wait access completes on its own accept edge, before the latches are loaded.
  assign acc_we      = (state == S_IDLE) ? we          : we_q;
  assign acc_addr    = (state == S_IDLE) ? addr[11:0]  : addr_q;
  assign acc_wdata   = (state == S_IDLE) ? wdata       : wdata_q;
  assign acc_aligned = (acc_addr[1:0] == 2'b00);

`ifdef DM_RESP_WAIT_EN
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= 4'(WAIT_CYCLES - 1);
    end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end
`else
  logic [3:0] unused_wait;
  assign unused_wait = 4'(WAIT_CYCLES);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
`ifdef DM_RESP_WAIT_EN
          state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
`else
          state_nxt = S_RESP;
`endif
        end
      end
`ifdef DM_RESP_WAIT_EN
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_RESP;
        end
      end
`endif
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack       = (state == S_RESP);
    busy      = (state != S_IDLE);
    state_dbg = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= 12'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      we_q    <= we;
      addr_q  <= addr[11:0];
      wdata_q <= wdata;
    end
  end

  // Storage is deliberately outside reset; rst only blocks a commit that has not happened yet.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_we && acc_aligned) begin
      mem[acc_addr[11:2]] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= 32'd0;
      err   <= 1'b0;
    end else if (enter_resp) begin
      if (!acc_aligned) begin
        rdata <= 32'd0;
        err   <= 1'b1;
      end else begin
        rdata <= acc_we ? acc_wdata : mem[acc_addr[11:2]];
        err   <= 1'b0;
      end
    end
  end

endmodule
